// File: rtl/execute_stage_pkg.sv
// Shared Y86-64 execute-stage constants: instruction codes, ALU functions,
// condition codes and the branch/cmov condition evaluator.
package execute_stage_pkg;

    localparam logic [3:0] IHALT   = 4'h0;
    localparam logic [3:0] INOP    = 4'h1;
    localparam logic [3:0] IRRMOVQ = 4'h2;
    localparam logic [3:0] IIRMOVQ = 4'h3;
    localparam logic [3:0] IRMMOVQ = 4'h4;
    localparam logic [3:0] IMRMOVQ = 4'h5;
    localparam logic [3:0] IOPQ    = 4'h6;
    localparam logic [3:0] IJXX    = 4'h7;
    localparam logic [3:0] ICALL   = 4'h8;
    localparam logic [3:0] IRET    = 4'h9;
    localparam logic [3:0] IPUSHQ  = 4'hA;
    localparam logic [3:0] IPOPQ   = 4'hB;

    typedef enum logic [1:0] {
        ALUADD = 2'b00,
        ALUSUB = 2'b01,
        ALUAND = 2'b10,
        ALUXOR = 2'b11
    } alu_fn_e;

    localparam logic [3:0] C_YES = 4'h0;
    localparam logic [3:0] C_LE  = 4'h1;
    localparam logic [3:0] C_L   = 4'h2;
    localparam logic [3:0] C_E   = 4'h3;
    localparam logic [3:0] C_NE  = 4'h4;
    localparam logic [3:0] C_GE  = 4'h5;
    localparam logic [3:0] C_G   = 4'h6;

    // cc is packed {ZF, SF, OF}
    function automatic logic cond_eval(input logic [3:0] fn, input logic [2:0] cc);
        logic zf, sf, of;
        zf = cc[2];
        sf = cc[1];
        of = cc[0];
        case (fn)
            C_YES:   cond_eval = 1'b1;
            C_LE:    cond_eval = (sf ^ of) | zf;
            C_L:     cond_eval = sf ^ of;
            C_E:     cond_eval = zf;
            C_NE:    cond_eval = !zf;
            C_GE:    cond_eval = !(sf ^ of);
            C_G:     cond_eval = !(sf ^ of) && !zf;
            default: cond_eval = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/execute_stage_if.sv
// Handshake and data bundle between decode, execute and memory stages.
interface execute_stage_if #(parameter int DATA_W = 64);
    logic              in_valid;
    logic              in_ready;
    logic [3:0]        icode;
    logic [3:0]        ifun;
    logic [DATA_W-1:0] valA;
    logic [DATA_W-1:0] valB;
    logic [DATA_W-1:0] valC;
    logic              out_valid;
    logic              out_ready;
    logic [3:0]        out_icode;
    logic [DATA_W-1:0] valE;
    logic              cnd;
    logic [2:0]        cc;
    logic              out_err;

    modport slave (
        input  in_valid, icode, ifun, valA, valB, valC, out_ready,
        output in_ready, out_valid, out_icode, valE, cnd, cc, out_err
    );

    modport master (
        output in_valid, icode, ifun, valA, valB, valC, out_ready,
        input  in_ready, out_valid, out_icode, valE, cnd, cc, out_err
    );
endinterface

// File: rtl/execute_stage_alu.sv
// Combinational ALU computing b op a with signed overflow for add/sub.
module execute_stage_alu
    import execute_stage_pkg::*;
#(
    parameter int DATA_W = 64
) (
    output logic [DATA_W-1:0] ans,
    output logic              overflow,
    input  alu_fn_e           control,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b
);
    always_comb begin
        ans      = '0;
        overflow = 1'b0;
        case (control)
            ALUADD: begin
                ans      = b + a;
                overflow = (a[DATA_W-1] == b[DATA_W-1]) && (ans[DATA_W-1] != b[DATA_W-1]);
            end
            ALUSUB: begin
                ans      = b - a;
                overflow = (a[DATA_W-1] != b[DATA_W-1]) && (ans[DATA_W-1] != b[DATA_W-1]);
            end
            ALUAND:  ans = b & a;
            ALUXOR:  ans = b ^ a;
            default: ans = '0;
        endcase
    end
endmodule

// File: rtl/execute_stage.sv
// Y86-64 execute stage: operand select, ALU, flags, condition evaluation and
// a one-entry output register with valid/ready handshake.
module execute_stage
    import execute_stage_pkg::*;
#(
    parameter int DATA_W = 64
) (
    input  logic clk,
    input  logic rst,
    execute_stage_if.slave bus
);
    localparam logic [DATA_W-1:0] K_EIGHT     = DATA_W'(8);
    localparam logic [DATA_W-1:0] K_NEG_EIGHT = '0 - K_EIGHT;

    logic              r_out_valid;
    logic [DATA_W-1:0] r_valE;
    logic              r_cnd;
    logic [3:0]        r_out_icode;
    logic              r_out_err;
    logic [2:0]        r_cc;

    logic              w_in_ready;
    logic              w_accept;
    logic              w_illegal;
    logic [DATA_W-1:0] w_alu_a;
    logic [DATA_W-1:0] w_alu_b;
    alu_fn_e           w_alu_fn;
    logic [DATA_W-1:0] w_alu_ans;
    logic              w_alu_of;
    logic              w_cnd;
    logic              w_cc_upd;
    logic [2:0]        w_cc_new;

    assign w_in_ready = !r_out_valid || bus.out_ready;
    assign w_accept   = bus.in_valid && w_in_ready;

    always_comb begin
        w_illegal = 1'b0;
        case (bus.icode)
            IOPQ:           w_illegal = bus.ifun > 4'd3;
            IRRMOVQ, IJXX:  w_illegal = bus.ifun > 4'd6;
            IHALT, INOP, IIRMOVQ, IRMMOVQ, IMRMOVQ,
            ICALL, IRET, IPUSHQ, IPOPQ:
                            w_illegal = bus.ifun != 4'd0;
            default:        w_illegal = 1'b1;
        endcase
    end

    always_comb begin
        w_alu_a = '0;
        w_alu_b = '0;
        case (bus.icode)
            IRRMOVQ:                   w_alu_a = bus.valA;
            IOPQ:                      w_alu_a = bus.valA;
            IIRMOVQ, IRMMOVQ, IMRMOVQ: w_alu_a = bus.valC;
            ICALL, IPUSHQ:             w_alu_a = K_NEG_EIGHT;
            IRET, IPOPQ:               w_alu_a = K_EIGHT;
            default:                   w_alu_a = '0;
        endcase
        case (bus.icode)
            IRMMOVQ, IMRMOVQ, IOPQ, ICALL, IRET, IPUSHQ, IPOPQ: w_alu_b = bus.valB;
            default:                                            w_alu_b = '0;
        endcase
    end

    assign w_alu_fn = (bus.icode == IOPQ) ? alu_fn_e'(bus.ifun[1:0]) : ALUADD;

    execute_stage_alu #(.DATA_W(DATA_W)) u_alu (
        .ans      (w_alu_ans),
        .overflow (w_alu_of),
        .control  (w_alu_fn),
        .a        (w_alu_a),
        .b        (w_alu_b)
    );

    // Condition uses the flags as they stand before this instruction's own update
    always_comb begin
        w_cnd = 1'b1;
        if (w_illegal)
            w_cnd = 1'b0;
        else if (bus.icode == IJXX || bus.icode == IRRMOVQ)
            w_cnd = cond_eval(bus.ifun, r_cc);
    end

    assign w_cc_upd = w_accept && (bus.icode == IOPQ) && !w_illegal;
    assign w_cc_new = {(w_alu_ans == '0), w_alu_ans[DATA_W-1], w_alu_of};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_out_valid <= 1'b0;
            r_valE      <= '0;
            r_cnd       <= 1'b0;
            r_out_icode <= 4'h0;
            r_out_err   <= 1'b0;
            r_cc        <= 3'b100;
        end else begin
            if (w_accept) begin
                r_out_valid <= 1'b1;
                r_valE      <= w_illegal ? '0 : w_alu_ans;
                r_cnd       <= w_cnd;
                r_out_icode <= bus.icode;
                r_out_err   <= w_illegal;
            end else if (bus.out_ready) begin
                r_out_valid <= 1'b0;
            end
            if (w_cc_upd)
                r_cc <= w_cc_new;
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.valE      = r_valE;
    assign bus.cnd       = r_cnd;
    assign bus.out_icode = r_out_icode;
    assign bus.out_err   = r_out_err;
    assign bus.cc        = r_cc;

endmodule

// File: tb/tb_execute_stage.sv
// Self-checking bench for execute_stage: directed vector table plus stall and
// reset sequences.
module tb_execute_stage;

    logic clk;
    logic rst;
    int   errors;
    int   checks;

    execute_stage_if #(.DATA_W(64)) bus_if ();

    execute_stage #(.DATA_W(64)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic [3:0]  icode;
        logic [3:0]  ifun;
        logic [63:0] a;
        logic [63:0] b;
        logic [63:0] c;
        logic [63:0] e_valE;
        logic        e_cnd;
        logic        e_err;
        logic [2:0]  e_cc;
    } vec_t;

    localparam int NV = 28;
    vec_t vec [NV];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [3:0] ic, input logic [3:0] fn,
                         input logic [63:0] a, input logic [63:0] b, input logic [63:0] c);
        bus_if.in_valid = v;
        bus_if.icode    = ic;
        bus_if.ifun     = fn;
        bus_if.valA     = a;
        bus_if.valB     = b;
        bus_if.valC     = c;
    endtask

    initial begin
        errors = 0;
        checks = 0;
        //          icode ifun  valA                   valB                   valC     valE                   cnd   err   cc
        vec[0]  = '{4'h6, 4'h1, 64'd4,                 64'd11,                64'd0,   64'd7,                 1'b1, 1'b0, 3'b000};
        vec[1]  = '{4'h6, 4'h0, 64'd1,                 64'h7FFF_FFFF_FFFF_FFFF, 64'd0, 64'h8000_0000_0000_0000, 1'b1, 1'b0, 3'b011};
        vec[2]  = '{4'h7, 4'h2, 64'd3,                 64'd4,                 64'h40,  64'd0,                 1'b0, 1'b0, 3'b011};
        vec[3]  = '{4'h7, 4'h1, 64'd0,                 64'd0,                 64'h40,  64'd0,                 1'b0, 1'b0, 3'b011};
        vec[4]  = '{4'h6, 4'h3, 64'd5,                 64'd5,                 64'd0,   64'd0,                 1'b1, 1'b0, 3'b100};
        vec[5]  = '{4'h7, 4'h3, 64'd0,                 64'd0,                 64'h80,  64'd0,                 1'b1, 1'b0, 3'b100};
        vec[6]  = '{4'h7, 4'h4, 64'd0,                 64'd0,                 64'h80,  64'd0,                 1'b0, 1'b0, 3'b100};
        vec[7]  = '{4'hA, 4'h0, 64'd9,                 64'h100,               64'd0,   64'hF8,                1'b1, 1'b0, 3'b100};
        vec[8]  = '{4'hB, 4'h0, 64'd9,                 64'h100,               64'd0,   64'h108,               1'b1, 1'b0, 3'b100};
        vec[9]  = '{4'h3, 4'h0, 64'd1,                 64'h55,                64'h1234, 64'h1234,             1'b1, 1'b0, 3'b100};
        vec[10] = '{4'h4, 4'h0, 64'd1,                 64'h20,                64'h10,  64'h30,                1'b1, 1'b0, 3'b100};
        vec[11] = '{4'h2, 4'h0, 64'hAB,                64'h99,                64'd7,   64'hAB,                1'b1, 1'b0, 3'b100};
        vec[12] = '{4'h2, 4'h6, 64'h5,                 64'h99,                64'd7,   64'h5,                 1'b0, 1'b0, 3'b100};
        vec[13] = '{4'h6, 4'h2, 64'hF0,                64'h3C,                64'd0,   64'h30,                1'b1, 1'b0, 3'b000};
        vec[14] = '{4'h6, 4'h1, 64'd2,                 64'd1,                 64'd0,   64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0, 3'b010};
        vec[15] = '{4'h7, 4'h2, 64'd0,                 64'd0,                 64'd0,   64'd0,                 1'b1, 1'b0, 3'b010};
        vec[16] = '{4'h7, 4'h5, 64'd0,                 64'd0,                 64'd0,   64'd0,                 1'b0, 1'b0, 3'b010};
        vec[17] = '{4'hC, 4'h0, 64'd1,                 64'd2,                 64'd3,   64'd0,                 1'b0, 1'b1, 3'b010};
        vec[18] = '{4'h6, 4'h4, 64'd1,                 64'd2,                 64'd0,   64'd0,                 1'b0, 1'b1, 3'b010};
        vec[19] = '{4'h7, 4'h7, 64'd0,                 64'd0,                 64'd0,   64'd0,                 1'b0, 1'b1, 3'b010};
        vec[20] = '{4'h1, 4'h1, 64'd0,                 64'd0,                 64'd0,   64'd0,                 1'b0, 1'b1, 3'b010};
        vec[21] = '{4'h8, 4'h0, 64'd0,                 64'h200,               64'h99,  64'h1F8,               1'b1, 1'b0, 3'b010};
        vec[22] = '{4'h9, 4'h0, 64'd0,                 64'h1F8,               64'd0,   64'h200,               1'b1, 1'b0, 3'b010};
        vec[23] = '{4'h0, 4'h0, 64'd5,                 64'd6,                 64'd7,   64'd0,                 1'b1, 1'b0, 3'b010};
        vec[24] = '{4'h5, 4'h0, 64'd3,                 64'h100,               64'd8,   64'h108,               1'b1, 1'b0, 3'b010};
        vec[25] = '{4'h6, 4'h1, 64'd1,                 64'h8000_0000_0000_0000, 64'd0, 64'h7FFF_FFFF_FFFF_FFFF, 1'b1, 1'b0, 3'b001};
        vec[26] = '{4'h7, 4'h1, 64'd0,                 64'd0,                 64'd0,   64'd0,                 1'b1, 1'b0, 3'b001};
        vec[27] = '{4'h7, 4'h6, 64'd0,                 64'd0,                 64'd0,   64'd0,                 1'b0, 1'b0, 3'b001};

        rst = 1'b1;
        bus_if.out_ready = 1'b1;
        drive(1'b0, 4'h0, 4'h0, 64'd0, 64'd0, 64'd0);
        repeat (2) @(negedge clk);
        chk("rst_out_valid", {63'd0, bus_if.out_valid}, 64'd0);
        chk("rst_valE",      bus_if.valE, 64'd0);
        chk("rst_cnd",       {63'd0, bus_if.cnd}, 64'd0);
        chk("rst_out_icode", {60'd0, bus_if.out_icode}, 64'd0);
        chk("rst_out_err",   {63'd0, bus_if.out_err}, 64'd0);
        chk("rst_cc",        {61'd0, bus_if.cc}, 64'd4);
        rst = 1'b0;
        #1;
        chk("post_rst_in_ready", {63'd0, bus_if.in_ready}, 64'd1);

        // Back-to-back accepts, one per cycle, with downstream always ready
        for (int i = 0; i < NV; i++) begin
            @(negedge clk);
            drive(1'b1, vec[i].icode, vec[i].ifun, vec[i].a, vec[i].b, vec[i].c);
            @(posedge clk);
            @(negedge clk);
            chk($sformatf("v%0d_out_valid", i), {63'd0, bus_if.out_valid}, 64'd1);
            chk($sformatf("v%0d_out_icode", i), {60'd0, bus_if.out_icode}, {60'd0, vec[i].icode});
            chk($sformatf("v%0d_valE", i),      bus_if.valE, vec[i].e_valE);
            chk($sformatf("v%0d_cnd", i),       {63'd0, bus_if.cnd}, {63'd0, vec[i].e_cnd});
            chk($sformatf("v%0d_err", i),       {63'd0, bus_if.out_err}, {63'd0, vec[i].e_err});
            chk($sformatf("v%0d_cc", i),        {61'd0, bus_if.cc}, {61'd0, vec[i].e_cc});
            chk($sformatf("v%0d_in_ready", i),  {63'd0, bus_if.in_ready}, 64'd1);
        end
        drive(1'b0, 4'h0, 4'h0, 64'd0, 64'd0, 64'd0);
        @(posedge clk);
        @(negedge clk);
        chk("drain_out_valid", {63'd0, bus_if.out_valid}, 64'd0);

        // Stall: hold addq result while downstream refuses three cycles
        drive(1'b1, 4'h6, 4'h0, 64'd2, 64'd3, 64'd0);
        @(posedge clk);
        @(negedge clk);
        chk("stall_first_valE", bus_if.valE, 64'd5);
        bus_if.out_ready = 1'b0;
        drive(1'b1, 4'hA, 4'h0, 64'd0, 64'h100, 64'd0);
        for (int k = 0; k < 3; k++) begin
            #1;
            chk($sformatf("stall%0d_in_ready", k),  {63'd0, bus_if.in_ready}, 64'd0);
            @(posedge clk);
            @(negedge clk);
            chk($sformatf("stall%0d_out_valid", k), {63'd0, bus_if.out_valid}, 64'd1);
            chk($sformatf("stall%0d_valE", k),      bus_if.valE, 64'd5);
            chk($sformatf("stall%0d_icode", k),     {60'd0, bus_if.out_icode}, 64'd6);
            chk($sformatf("stall%0d_cc", k),        {61'd0, bus_if.cc}, 64'd0);
        end
        bus_if.out_ready = 1'b1;
        #1;
        chk("release_in_ready", {63'd0, bus_if.in_ready}, 64'd1);
        @(posedge clk);
        @(negedge clk);
        chk("release_out_valid", {63'd0, bus_if.out_valid}, 64'd1);
        chk("release_valE",      bus_if.valE, 64'hF8);
        chk("release_icode",     {60'd0, bus_if.out_icode}, 64'hA);

        // Illegal icode then reset while the result is held
        drive(1'b1, 4'hC, 4'h0, 64'd1, 64'd1, 64'd1);
        @(posedge clk);
        @(negedge clk);
        chk("ill_err", {63'd0, bus_if.out_err}, 64'd1);
        chk("ill_cnd", {63'd0, bus_if.cnd}, 64'd0);
        chk("ill_cc",  {61'd0, bus_if.cc}, 64'd0);
        bus_if.out_ready = 1'b0;
        drive(1'b1, 4'h6, 4'h1, 64'd1, 64'd9, 64'd0);
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("midrst_out_valid", {63'd0, bus_if.out_valid}, 64'd0);
        chk("midrst_cc",        {61'd0, bus_if.cc}, 64'd4);
        chk("midrst_err",       {63'd0, bus_if.out_err}, 64'd0);
        @(negedge clk);
        drive(1'b0, 4'h0, 4'h0, 64'd0, 64'd0, 64'd0);
        rst = 1'b0;
        #1;
        chk("after_rst_in_ready", {63'd0, bus_if.in_ready}, 64'd1);
        @(posedge clk);
        @(negedge clk);
        chk("after_rst_out_valid", {63'd0, bus_if.out_valid}, 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/execute_stage.md
EXECUTE_STAGE -- requirements
Module: execute_stage

Interface
REQ-001 Parameter: DATA_W, default 64, operand/result width; only 64 is supported.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 in_valid  input  1  upstream (decode) holds an instruction.
REQ-005 in_ready  output  1  stage can accept an instruction this cycle.
REQ-006 icode, ifun  input  4 each  Y86-64 instruction code and function.
REQ-007 valA, valB, valC  input  DATA_W each  decoded operands and constant.
REQ-008 out_valid  output  1  registered result available.
REQ-009 out_ready  input  1  downstream (memory stage) accepts result.
REQ-010 out_icode  output  4  icode of the held result.
REQ-011 valE  output  DATA_W  registered ALU result.
REQ-012 cnd  output  1  registered condition outcome for jXX/cmovXX; 1 for all other icodes.
REQ-013 cc  output  3  architectural flags {ZF,SF,OF}.
REQ-014 out_err  output  1  held instruction had illegal icode (>0xB) or illegal ifun.

Function
REQ-015 Transfer occurs when in_valid && in_ready; in_ready = !out_valid || out_ready (one-entry pipeline register, full throughput).
REQ-016 Latency: one cycle from accept to out_valid=1; out_valid holds, with valE/cnd/out_icode/out_err stable, until out_valid && out_ready.
REQ-017 Accept and drain in the same cycle: new result replaces old, out_valid stays 1.
REQ-018 aluA: valA for rrmovq(2) and OPq(6); valC for irmovq(3), rmmovq(4), mrmovq(5); -8 for call(8), pushq(A); +8 for ret(9), popq(B); 0 otherwise.
REQ-019 aluB: valB for 4,5,6,8,9,A,B; 0 for 2, 3 and all others.
REQ-020 ALU function: ifun[1:0] for OPq (00 add, 01 sub, 10 and, 11 xor); add for all other icodes.
REQ-021 ALU computes aluB op aluA (subq yields valB - valA), two's-complement, result truncated to DATA_W.
REQ-022 OF = signed overflow for add/sub, 0 for and/xor; ZF = (result == 0); SF = result[63].
REQ-023 cc updates only on acceptance of OPq with ifun <= 3; no other instruction, stall or drain changes cc.
REQ-024 cnd evaluated at acceptance against cc value before this instruction's update: ifun 0 always, 1 le (SF^OF)|ZF, 2 l SF^OF, 3 e ZF, 4 ne !ZF, 5 ge !(SF^OF), 6 g !(SF^OF)&!ZF.
REQ-025 Illegal: icode > 0xB, OPq ifun > 3, jXX/cmovXX ifun > 6, other icodes ifun != 0 -> out_err=1, cnd=0, cc unchanged, valE=0.
REQ-026 Back-to-back OPq then jXX: jXX sees cc produced by the OPq accepted the previous cycle.

Reset
REQ-027 On rst: out_valid=0, valE=0, cnd=0, out_icode=0, out_err=0, cc=3'b100 (ZF=1, SF=0, OF=0).
REQ-028 rst mid-transfer discards the held result; in_ready=1 in the first cycle after rst deasserts.

Structure
REQ-029 Shared package holds icode constants (IHALT..IPOPQ), ALU function codes (ALUADD, ALUSUB, ALUAND, ALUXOR) and condition ifun codes.
REQ-030 Combinational arithmetic instantiates the existing alu sub-module (port order ans, overflow, control, a, b); execute_stage adds operand muxing, flag logic, condition evaluation and handshake registers.

Verification
REQ-031 OPq subq valA=4, valB=11 -> valE=7, cc=000 next cycle, out_valid=1 after one cycle.
REQ-032 OPq addq valA=1, valB=0x7FFF_FFFF_FFFF_FFFF -> valE=0x8000_0000_0000_0000, cc=011.
REQ-033 OPq xorq valA=valB=0x5 then jXX ifun=3 (je) -> cc=100, cnd=1; following jne -> cnd=0.
REQ-034 pushq valB=0x100 -> valE=0xF8, cc unchanged; popq valB=0x100 -> valE=0x108.
REQ-035 out_ready=0 for 3 cycles with in_valid=1 -> in_ready=0, outputs stable, no second accept; out_ready=1 -> drain and accept same cycle.
REQ-036 icode=0xC -> out_err=1, cnd=0, cc unchanged; rst asserted while out_valid=1 -> out_valid=0, cc=100 immediately.
